// File: rtl/ysyx_23060096_imem_responder.sv
// rtl/ysyx_23060096_imem_responder.sv - instruction-memory fetch responder with byte-strobed loader port
// Optional IMEM_RAND_DELAY_EN adds 0..3 cycles of LFSR-driven latency jitter per fetch.
module ysyx_23060096_imem_responder #(
   parameter int unsigned AW_WORDS  = 12,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic        resp_err,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb
);

   localparam int unsigned DEPTH  = 1 << AW_WORDS;
   localparam logic [32:0] SPAN   = 33'd1 << (AW_WORDS + 2);
   localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   resp_inst_q, resp_inst_d;
   logic          resp_err_q, resp_err_d;

   logic [31:0]   mem_q [DEPTH];
   logic [AW_WORDS-1:0] wr_idx;
   logic [AW_WORDS-1:0] fetch_idx;
   logic [31:0]   rd_word;
   logic          fetch_err;
   logic [4:0]    lat_init;

   // Offset is computed with wrapping 32-bit subtraction; the extra top bit
   // keeps the span comparison exact even when the array covers 4 GiB.
   function automatic logic in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
   endfunction

   assign wr_idx    = AW_WORDS'((wr_addr - BASE_ADDR) >> 2);
   assign fetch_idx = AW_WORDS'((addr_q - BASE_ADDR) >> 2);
   assign fetch_err = (addr_q[1:0] != 2'b00) || !in_range(addr_q);
   assign rd_word   = mem_q[fetch_idx];

   // Loader writes share the capture edge with fetches; the nonblocking update
   // makes a same-edge capture see the old word.
   always_ff @(posedge clk) begin
      if (wr_en && in_range(wr_addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
               mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

`ifdef IMEM_RAND_DELAY_EN
   logic [7:0] lfsr_q;
   logic       lfsr_fb;

   assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      end
   end

   assign lat_init = LAT_M1 + {3'b000, lfsr_q[1:0]};
`else
   assign lat_init = LAT_M1;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_inst_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         resp_valid_q <= resp_valid_d;
         resp_inst_q  <= resp_inst_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      resp_valid_d = resp_valid_q;
      resp_inst_d  = resp_inst_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               cnt_d   = lat_init;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               resp_valid_d = 1'b1;
               resp_err_d   = fetch_err;
               resp_inst_d  = fetch_err ? 32'h0 : rd_word;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req_ready  = rstn && (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_inst  = resp_inst_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_23060096_imem_responder.sv
// tb/tb_ysyx_23060096_imem_responder.sv - scoreboard bench for the imem responder
module tb_ysyx_23060096_imem_responder;

   localparam int LAT_A = 1;
   localparam int LAT_B = 4;
`ifdef IMEM_RAND_DELAY_EN
   localparam int XTRA = 3;
`else
   localparam int XTRA = 0;
`endif
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, req_valid, req_ready, resp_valid, resp_ready, resp_err, wr_en;
   logic [31:0] req_addr, resp_inst, wr_addr, wr_data;
   logic [3:0]  wr_strb;

   logic        b_rstn, b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err, b_wr_en;
   logic [31:0] b_req_addr, b_resp_inst, b_wr_addr, b_wr_data;
   logic [3:0]  b_wr_strb;

   ysyx_23060096_imem_responder #(.AW_WORDS(12), .BASE_ADDR(BASE), .LATENCY(LAT_A)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_inst(resp_inst), .resp_err(resp_err), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb)
   );

   ysyx_23060096_imem_responder #(.AW_WORDS(12), .BASE_ADDR(BASE), .LATENCY(LAT_B)) dut_b (
      .clk(clk), .rstn(b_rstn), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_inst(b_resp_inst), .resp_err(b_resp_err), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .wr_strb(b_wr_strb)
   );

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];
   logic [31:0] model [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic write_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic fetch_a(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                          input int hold, input logic cw, input logic [31:0] cwd);
      int n;
      logic [32:0] e;
      logic [31:0] held;
      exp_q.push_back({ee, ei});
      @(negedge clk);
      req_valid = 1'b1; req_addr = a;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      if (cw) begin
         wr_en = 1'b1; wr_addr = a; wr_data = cwd; wr_strb = 4'hF;
      end
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
         wr_en = 1'b0;
      end
      wr_en = 1'b0;
      check("latency_lo", 32'(n >= LAT_A), 32'd1);
      check("latency_hi", 32'(n <= LAT_A + XTRA), 32'd1);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'bx;
      check("resp_inst", resp_inst, e[31:0]);
      check("resp_err", 32'(resp_err), 32'(e[32]));
      held = resp_inst;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_inst", resp_inst, held);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("handoff_valid", 32'(resp_valid), 32'd0);
      check("next_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, saw, r, idx;
      logic [31:0] a, d;
      logic ee;

      rstn = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
      b_rstn = 1'b0; b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_inst", resp_inst, 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      rstn = 1'b1; b_rstn = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Basic fetch and error addresses, including the last in-range word.
      write_a(32'h8000_0000, 32'h0000_0513, 4'hF);
      fetch_a(32'h8000_0000, 32'h0000_0513, 1'b0, 0, 1'b0, '0);
      fetch_a(32'h8000_0002, 32'h0, 1'b1, 0, 1'b0, '0);
      fetch_a(32'h7FFF_FFFC, 32'h0, 1'b1, 0, 1'b0, '0);
      fetch_a(32'h8000_4000, 32'h0, 1'b1, 0, 1'b0, '0);
      fetch_a(32'hFFFF_FFFC, 32'h0, 1'b1, 0, 1'b0, '0);
      write_a(32'h8000_3FFC, 32'hDEAD_BEEF, 4'hF);
      fetch_a(32'h8000_3FFC, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, '0);
      write_a(32'h8000_4000, 32'h1234_5678, 4'hF);
      fetch_a(32'h8000_0000, 32'h0000_0513, 1'b0, 5, 1'b0, '0);

      // Byte strobes and write/capture ordering.
      write_a(32'h8000_0010, 32'h1122_3344, 4'hF);
      write_a(32'h8000_0013, 32'hAABB_CCDD, 4'b0101);
      fetch_a(32'h8000_0010, 32'h11BB_33DD, 1'b0, 0, 1'b0, '0);
`ifndef IMEM_RAND_DELAY_EN
      fetch_a(32'h8000_0010, 32'h11BB_33DD, 1'b0, 0, 1'b1, 32'h5566_7788);
      fetch_a(32'h8000_0010, 32'h5566_7788, 1'b0, 0, 1'b0, '0);
`endif

      // Reset while the LATENCY=4 instance is waiting.
      @(negedge clk);
      b_wr_en = 1'b1; b_wr_addr = 32'h8000_0100; b_wr_data = 32'hCAFE_F00D; b_wr_strb = 4'hF;
      @(negedge clk);
      b_wr_en = 1'b0;
      b_req_valid = 1'b1; b_req_addr = 32'h8000_0100;
      @(negedge clk);
      b_req_valid = 1'b0;
      check("b_wait_req_ready", 32'(b_req_ready), 32'd0);
      @(negedge clk);
      b_rstn = 1'b0;
      @(negedge clk);
      check("b_rst_valid", 32'(b_resp_valid), 32'd0);
      check("b_rst_req_ready", 32'(b_req_ready), 32'd0);
      @(negedge clk);
      b_rstn = 1'b1;
      saw = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b_resp_valid) saw++;
      end
      check("b_no_resp_pulse", 32'(saw), 32'd0);
      check("b_idle_req_ready", 32'(b_req_ready), 32'd1);
      exp_q.push_back({1'b0, 32'hCAFE_F00D});
      b_req_valid = 1'b1; b_req_addr = 32'h8000_0100;
      @(negedge clk);
      b_req_valid = 1'b0;
      n = 0;
      while (!b_resp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("b_latency_lo", 32'(n >= LAT_B), 32'd1);
      check("b_latency_hi", 32'(n <= LAT_B + XTRA), 32'd1);
      check("b_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         logic [32:0] e;
         e = exp_q.pop_front();
         check("b_resp_inst", b_resp_inst, e[31:0]);
         check("b_resp_err", 32'(b_resp_err), 32'(e[32]));
      end
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
      check("b_handoff_valid", 32'(b_resp_valid), 32'd0);

      // Random fetches against a word model, with interleaved loader writes.
      for (int i = 0; i < 16; i++) begin
         model[i] = $urandom;
         write_a(BASE + 32'(4 * i), model[i], 4'hF);
      end
      for (int k = 0; k < 200; k++) begin
         r   = int'($urandom_range(0, 9));
         idx = int'($urandom_range(0, 15));
         a   = BASE + 32'(4 * idx);
         d   = model[idx];
         ee  = 1'b0;
         if (r == 0) begin
            a  = a + 32'($urandom_range(1, 3));
            d  = 32'h0; ee = 1'b1;
         end else if (r == 1) begin
            a  = BASE - 32'(4 * $urandom_range(1, 8));
            d  = 32'h0; ee = 1'b1;
         end else if (r == 2) begin
            a  = 32'h8000_4000 + 32'(4 * idx);
            d  = 32'h0; ee = 1'b1;
         end else if (r == 3) begin
            model[idx] = $urandom;
            write_a(a, model[idx], 4'hF);
            d = model[idx];
         end
         fetch_a(a, d, ee, int'($urandom_range(0, 2)), 1'b0, '0);
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
